// File: rtl/mem_access_scheduler_if.sv
// Bus bundle between the memory access scheduler, its requesters, the RAM and the
// response consumers. The slave modport is the scheduler's view.
interface mem_access_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;

    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_waddr;
    logic [DATA_W-1:0]         ram_wdata;
    logic [ADDR_W-1:0]         ram_raddr;
    logic [DATA_W-1:0]         ram_rdata;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_req_id;
    logic [TAG_W-1:0]          rsp_tag;
    logic [DATA_W-1:0]         rsp_data;

    logic                      busy;
    logic [31:0]               stat_reads;
    logic [31:0]               stat_writes;
    logic [31:0]               stat_stalls;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_tag, ram_rdata,
        input  req_ready, ram_we, ram_waddr, ram_wdata, ram_raddr,
               rsp_valid, rsp_req_id, rsp_tag, rsp_data,
               busy, stat_reads, stat_writes, stat_stalls
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_tag, ram_rdata,
        output req_ready, ram_we, ram_waddr, ram_wdata, ram_raddr,
               rsp_valid, rsp_req_id, rsp_tag, rsp_data,
               busy, stat_reads, stat_writes, stat_stalls
    );
endinterface

// File: rtl/mem_access_scheduler.sv
// Round-robin arbiter + in-order request queue sharing one RAM between NUM_REQ requesters.
// Optional access/stall counters are built only when SCHED_STATS_EN is defined.
module mem_access_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 8,
    parameter int DEPTH   = 8,
    parameter int RD_LAT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_scheduler_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
        logic [ID_W-1:0]   id;
    } entry_t;

    entry_t            fifo_q [2**PTR_W];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    entry_t            push_entry;
    entry_t            head;
    logic              push, pop, iss_rd, iss_wr;

    logic              fin_valid;
    logic [ID_W-1:0]   fin_id;
    logic [TAG_W-1:0]  fin_tag;
    logic              pipe_busy;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [DATA_W-1:0] rsp_data_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: a requester holds req_valid and its payload stable until it sees
    // req_ready; the transfer happens on the edge where both are high. At most one
    // req_ready is set, and none while the queue is full.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        if (count_q != CNT_W'(DEPTH)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_valid && bus.req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = idx;
                end
            end
        end
    end

    always_comb begin
        push_entry    = '0;
        push_entry.id = grant_id;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                push_entry.we    = bus.req_we[k];
                push_entry.addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
                push_entry.wdata = bus.req_wdata[k*DATA_W +: DATA_W];
                push_entry.tag   = bus.req_tag[k*TAG_W +: TAG_W];
            end
        end
    end

    assign bus.req_ready = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;

    assign push   = grant_valid;
    assign pop    = (count_q != '0);
    assign head   = fifo_q[rd_ptr_q];
    assign iss_wr = pop & head.we;
    assign iss_rd = pop & ~head.we;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
        raddr_d = iss_rd ? head.addr : raddr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            raddr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            raddr_q  <= raddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.ram_we    = iss_wr;
    assign bus.ram_waddr = iss_wr ? head.addr : '0;
    assign bus.ram_wdata = iss_wr ? head.wdata : '0;
    assign bus.ram_raddr = raddr_d;

    // Reads in flight carry {valid, id, tag} until ram_rdata is valid for them.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign fin_valid = iss_rd;
            assign fin_id    = head.id;
            assign fin_tag   = head.tag;
            assign pipe_busy = 1'b0;
        end else begin : g_latn
            logic [RD_LAT-1:0] v_q;
            logic [ID_W-1:0]   id_q  [RD_LAT];
            logic [TAG_W-1:0]  tag_q [RD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= iss_rd;
                    for (int k = 1; k < RD_LAT; k++) begin
                        v_q[k] <= v_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                id_q[0]  <= head.id;
                tag_q[0] <= head.tag;
                for (int k = 1; k < RD_LAT; k++) begin
                    id_q[k]  <= id_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end

            assign fin_valid = v_q[RD_LAT-1];
            assign fin_id    = id_q[RD_LAT-1];
            assign fin_tag   = tag_q[RD_LAT-1];
            assign pipe_busy = |v_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= fin_valid;
            if (fin_valid) begin
                rsp_id_q   <= fin_id;
                rsp_tag_q  <= fin_tag;
                rsp_data_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_req_id = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (count_q != '0) | pipe_busy;

`ifdef SCHED_STATS_EN
    logic [31:0] stat_reads_q, stat_writes_q, stat_stalls_q;
    logic        stall;

    assign stall = (|bus.req_valid) && (count_q == CNT_W'(DEPTH));

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (iss_rd && stat_reads_q != '1)  stat_reads_q  <= stat_reads_q + 32'd1;
            if (iss_wr && stat_writes_q != '1) stat_writes_q <= stat_writes_q + 32'd1;
            if (stall && stat_stalls_q != '1)  stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign bus.stat_reads  = stat_reads_q;
    assign bus.stat_writes = stat_writes_q;
    assign bus.stat_stalls = stat_stalls_q;
`else
    assign bus.stat_reads  = '0;
    assign bus.stat_writes = '0;
    assign bus.stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Bench for mem_access_scheduler: directed timing sequences, a round-robin vector table
// and a randomized run against a queue-based reference model.
module tb_mem_access_scheduler;
    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int IW = 2;
    localparam int EW = IW + TW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ram_init;

    logic [NR-1:0]    rv, rwe, rv_c;
    logic [NR*AW-1:0] raddr, raddr_c;
    logic [NR*DW-1:0] rwd;
    logic [NR*TW-1:0] rtag;

    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];
    logic [DW-1:0] mem_c [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] rdata_b;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_a [$];
    logic [EW-1:0] exp_b [$];
    int            m_cnt, m_ptr, n_rd, n_wr;
    logic [NR-1:0] acc;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] exp_ready;
    } vec_t;
    vec_t vecs [9];

    mem_access_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) ifa ();
    mem_access_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) ifb ();
    mem_access_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) ifc ();

    mem_access_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW),
                           .DEPTH(8), .RD_LAT(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mem_access_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW),
                           .DEPTH(8), .RD_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mem_access_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW),
                           .DEPTH(1), .RD_LAT(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.req_valid = rv;
    assign ifa.req_we    = rwe;
    assign ifa.req_addr  = raddr;
    assign ifa.req_wdata = rwd;
    assign ifa.req_tag   = rtag;
    assign ifb.req_valid = rv;
    assign ifb.req_we    = rwe;
    assign ifb.req_addr  = raddr;
    assign ifb.req_wdata = rwd;
    assign ifb.req_tag   = rtag;
    assign ifc.req_valid = rv_c;
    assign ifc.req_we    = '0;
    assign ifc.req_addr  = raddr_c;
    assign ifc.req_wdata = '0;
    assign ifc.req_tag   = '0;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 52) return 16'h1210;
        if (i == 54) return 16'h0e10;
        return 16'(i * 263) ^ 16'h3c00;
    endfunction

    // RAM models: a and c are asynchronous arrays, b is a registered block RAM.
    assign ifa.ram_rdata = mem_a[ifa.ram_raddr[9:0]];
    assign ifb.ram_rdata = rdata_b;
    assign ifc.ram_rdata = mem_c[ifc.ram_raddr[9:0]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
                mem_c[i] <= init_val(i);
            end
        end else begin
            if (ifa.ram_we) mem_a[ifa.ram_waddr[9:0]] <= ifa.ram_wdata;
            if (ifb.ram_we) mem_b[ifb.ram_waddr[9:0]] <= ifb.ram_wdata;
            if (ifc.ram_we) mem_c[ifc.ram_waddr[9:0]] <= ifc.ram_wdata;
        end
        rdata_b <= mem_b[ifb.ram_raddr[9:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ram_init = 1'b1;
        rv       = '0;
        rwe      = '0;
        raddr    = '0;
        rwd      = '0;
        rtag     = '0;
        rv_c     = '0;
        raddr_c  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_init = 1'b0;
        exp_a.delete();
        exp_b.delete();
        m_cnt = 0;
        m_ptr = 0;
        n_rd  = 0;
        n_wr  = 0;
        acc   = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic set_req(input int i, input logic we, input int addr,
                           input logic [DW-1:0] wd, input logic [TW-1:0] tag);
        rv[i]            = 1'b1;
        rwe[i]           = we;
        raddr[i*AW +: AW] = AW'(addr);
        rwd[i*DW +: DW]   = wd;
        rtag[i*TW +: TW]  = tag;
    endtask

    // Reference model step: called once per cycle between edges.
    task automatic sb_cycle();
        int            gid;
        int            j;
        logic [NR-1:0] exp_ready;
        logic [AW-1:0] a;
        gid = -1;
        if (m_cnt < 8) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (gid < 0 && rv[j]) gid = j;
            end
        end
        exp_ready = (gid >= 0) ? NR'(1 << gid) : '0;
        chk("ready_a", ifa.req_ready, exp_ready);
        chk("ready_b", ifb.req_ready, exp_ready);
        if (ifa.rsp_valid) begin
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_a_unexpected: got tag %0h expected no response", ifa.rsp_tag);
            end else begin
                chk("rsp_a", {ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data}, exp_a.pop_front());
            end
        end
        if (ifb.rsp_valid) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_b_unexpected: got tag %0h expected no response", ifb.rsp_tag);
            end else begin
                chk("rsp_b", {ifb.rsp_req_id, ifb.rsp_tag, ifb.rsp_data}, exp_b.pop_front());
            end
        end
        acc = rv & ifa.req_ready;
        if (gid >= 0) begin
            a = raddr[gid*AW +: AW];
            if (rwe[gid]) begin
                ref_mem[a[9:0]] = rwd[gid*DW +: DW];
                n_wr++;
            end else begin
                exp_a.push_back({IW'(gid), rtag[gid*TW +: TW], ref_mem[a[9:0]]});
                exp_b.push_back({IW'(gid), rtag[gid*TW +: TW], ref_mem[a[9:0]]});
                n_rd++;
            end
            m_ptr = (gid + 1) % NR;
        end
        m_cnt = m_cnt + ((gid >= 0) ? 1 : 0) - ((m_cnt != 0) ? 1 : 0);
    endtask

    initial begin
        vecs[0] = '{3'b111, 3'b001};
        vecs[1] = '{3'b101, 3'b100};
        vecs[2] = '{3'b110, 3'b010};
        vecs[3] = '{3'b011, 3'b001};
        vecs[4] = '{3'b001, 3'b001};
        vecs[5] = '{3'b000, 3'b000};
        vecs[6] = '{3'b011, 3'b010};
        vecs[7] = '{3'b100, 3'b100};
        vecs[8] = '{3'b110, 3'b010};

        // Single read: accept in cycle 1, RAM read in cycle 2, response in cycle 3 (b: 4).
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            rv = '0;
            if (c == 1) set_req(0, 1'b0, 52, '0, 8'h00);
            @(negedge clk);
            case (c)
                1: chk("single_ready", ifa.req_ready, 3'b001);
                2: begin
                    chk("single_raddr", ifa.ram_raddr, 16'd52);
                    chk("single_busy", ifa.busy, 1'b1);
                    chk("single_early", ifa.rsp_valid, 1'b0);
                end
                3: begin
                    chk("single_rsp", {ifa.rsp_valid, ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data},
                        {1'b1, 2'd0, 8'h00, 16'h1210});
                    chk("single_b_early", ifb.rsp_valid, 1'b0);
                end
                default: begin
                    chk("single_one_shot", ifa.rsp_valid, 1'b0);
                    chk("single_b_rsp", {ifb.rsp_valid, ifb.rsp_data}, {1'b1, 16'h1210});
                end
            endcase
            next_cycle();
        end

        // Round-robin between req0 and req1 held for four cycles.
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            rv = '0;
            if (c <= 4) begin
                set_req(0, 1'b0, 52, '0, 8'h10);
                set_req(1, 1'b0, 54, '0, 8'h21);
            end
            @(negedge clk);
            if (c <= 4) chk("rr_ready", ifa.req_ready, (c % 2 == 1) ? 3'b001 : 3'b010);
            if (c >= 3) begin
                if (c % 2 == 1)
                    chk("rr_rsp", {ifa.rsp_valid, ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data},
                        {1'b1, 2'd0, 8'h10, 16'h1210});
                else
                    chk("rr_rsp", {ifa.rsp_valid, ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data},
                        {1'b1, 2'd1, 8'h21, 16'h0e10});
            end
            next_cycle();
        end

        // Write then read of the same address.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            rv = '0;
            if (c == 1) set_req(2, 1'b1, 290, 16'hBEEF, 8'h44);
            if (c == 2) set_req(1, 1'b0, 290, '0, 8'h05);
            @(negedge clk);
            case (c)
                1: chk("wr_ready", ifa.req_ready, 3'b100);
                2: begin
                    chk("wr_ready2", ifa.req_ready, 3'b010);
                    chk("wr_strobe", {ifa.ram_we, ifa.ram_waddr, ifa.ram_wdata},
                        {1'b1, 16'd290, 16'hBEEF});
                end
                3: chk("wr_rd_issue", {ifa.ram_we, ifa.ram_raddr}, {1'b0, 16'd290});
                default: chk("wr_rd_rsp", {ifa.rsp_valid, ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data},
                             {1'b1, 2'd1, 8'h05, 16'hBEEF});
            endcase
            next_cycle();
        end

        // Reset values after activity.
        do_reset();
        @(negedge clk);
        chk("rst_ram", {ifa.ram_we, ifa.ram_waddr, ifa.ram_wdata, ifa.ram_raddr}, '0);
        chk("rst_rsp", {ifa.rsp_valid, ifa.rsp_req_id, ifa.rsp_tag, ifa.rsp_data}, '0);
        chk("rst_busy", {ifa.busy, ifb.busy, ifc.busy}, 3'b000);
        chk("rst_ready", ifa.req_ready, 3'b000);
        chk("rst_stats", {ifa.stat_reads, ifa.stat_writes}, '0);
        chk("rst_stalls", ifa.stat_stalls, 32'd0);
        next_cycle();

        // Back-to-back reads on the registered RAM.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            rv = '0;
            if (c <= 3) set_req(0, 1'b0, 50 + 2 * c, '0, TW'(c));
            @(negedge clk);
            if (c <= 3) begin
                chk("burst_ready", ifb.req_ready, 3'b001);
                chk("burst_idle", ifb.rsp_valid, 1'b0);
            end else if (c <= 6) begin
                chk("burst_rsp", {ifb.rsp_valid, ifb.rsp_tag, ifb.rsp_data},
                    {1'b1, 8'(c - 3), init_val(50 + 2 * (c - 3))});
            end else begin
                chk("burst_end", ifb.rsp_valid, 1'b0);
            end
            next_cycle();
        end

        // Full queue on a single-entry instance: all requesters hold valid.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            if (c <= 6) begin
                rv_c    = 3'b111;
                raddr_c = {16'd60, 16'd58, 16'd56};
            end else begin
                rv_c = '0;
            end
            @(negedge clk);
            case (c)
                1: chk("full_ready", ifc.req_ready, 3'b001);
                2: chk("full_ready", ifc.req_ready, 3'b000);
                3: chk("full_ready", ifc.req_ready, 3'b010);
                4: chk("full_ready", ifc.req_ready, 3'b000);
                5: chk("full_ready", ifc.req_ready, 3'b100);
                6: chk("full_ready", ifc.req_ready, 3'b000);
                default: begin
`ifdef SCHED_STATS_EN
                    chk("full_stalls", ifc.stat_stalls, 32'd3);
`else
                    chk("full_stalls", ifc.stat_stalls, 32'd0);
`endif
                end
            endcase
            if (c == 2) chk("full_busy", ifc.busy, 1'b1);
            next_cycle();
        end

        // Round-robin vector table, one vector per cycle from rr_ptr = 0.
        do_reset();
        for (int v = 0; v < 9; v++) begin
            rv = '0;
            for (int i = 0; i < NR; i++) begin
                if (vecs[v].valid[i]) set_req(i, 1'b0, 40 + i, '0, TW'(v));
            end
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), ifa.req_ready, vecs[v].exp_ready);
            next_cycle();
        end
        rv = '0;
        repeat (3) next_cycle();

        // Reset mid-operation: a read in flight on b and one queued read are discarded.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            rv = '0;
            if (c == 1) set_req(0, 1'b0, 52, '0, 8'h01);
            if (c == 2) set_req(1, 1'b0, 54, '0, 8'h02);
            rst = (c == 3);
            if (c == 4) set_req(0, 1'b0, 56, '0, 8'h03);
            @(negedge clk);
            case (c)
                4: begin
                    chk("mid_rst_rsp", {ifa.rsp_valid, ifb.rsp_valid}, 2'b00);
                    chk("mid_rst_busy", {ifa.busy, ifb.busy}, 2'b00);
                    chk("mid_rst_ready", ifa.req_ready, 3'b001);
                end
                5: chk("mid_rst_rsp", {ifa.rsp_valid, ifb.rsp_valid}, 2'b00);
                6: begin
                    chk("mid_rst_new_a", {ifa.rsp_valid, ifa.rsp_tag}, {1'b1, 8'h03});
                    chk("mid_rst_b_quiet", ifb.rsp_valid, 1'b0);
                end
                7: chk("mid_rst_new_b", {ifb.rsp_valid, ifb.rsp_tag}, {1'b1, 8'h03});
                default: ;
            endcase
            next_cycle();
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] || acc[i]) begin
                    rv[i] = 1'b0;
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, $urandom_range(0, 3) == 0, $urandom_range(40, 63),
                                DW'($urandom), TW'($urandom));
                end
            end
            @(negedge clk);
            sb_cycle();
            next_cycle();
        end
        rv = '0;
        for (int d = 0; d < 10; d++) begin
            @(negedge clk);
            sb_cycle();
            next_cycle();
        end
        chk("drain_a", exp_a.size(), 0);
        chk("drain_b", exp_b.size(), 0);
        @(negedge clk);
        chk("idle_busy", {ifa.busy, ifb.busy}, 2'b00);
`ifdef SCHED_STATS_EN
        chk("stat_reads", ifa.stat_reads, n_rd);
        chk("stat_writes", ifa.stat_writes, n_wr);
`else
        chk("stat_reads", ifa.stat_reads, 0);
        chk("stat_writes", ifa.stat_writes, 0);
`endif
        chk("stat_stalls", ifa.stat_stalls, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
